mac_check_engine: RTL and testbench

MAC_CHECK_ENGINE -- requirements
Module: mac_check_engine

---
 rtl/mac_check_pkg.sv | 35 +++
 rtl/mac_check_engine_if.sv | 35 +++
 rtl/mac_check_lfsr.sv | 25 ++
 rtl/mac_check_engine.sv | 164 ++++++++++++++++
 tb/tb_mac_check_engine.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_check_pkg.sv
// Shared types and constants for the MAC check engine: FSM states, stimulus
// edge-case modes and the Galois LFSR step/seed helpers.
package mac_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DONE_PASS,
        ST_DONE_FAIL
    } state_t;

    localparam logic [2:0] EC_RANDOM = 3'd0;
    localparam logic [2:0] EC_A_ZERO = 3'd1;
    localparam logic [2:0] EC_A_ONES = 3'd2;
    localparam logic [2:0] EC_B_ZERO = 3'd3;
    localparam logic [2:0] EC_B_ONES = 3'd4;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois form: the bit shifted out selects the tap XOR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Per-operand seed: rotate left by operand index; an all-zero seed would lock up.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] seed, input int unsigned k);
        int unsigned sh;
        logic [31:0] r;
        sh = k % 32;
        r  = (sh == 0) ? seed : ((seed << sh) | (seed >> (32 - sh)));
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/mac_check_engine_if.sv
// Control, stimulus and result bundle between a test controller (master)
// and the MAC check engine (slave).
interface mac_check_engine_if #(
    parameter int NUM_CH    = 4,
    parameter int MIN_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 32
);
    logic                        cset;
    logic                        start;
    logic [CNT_WIDTH-1:0]        num_tests;
    logic [2:0]                  edgecase;
    logic [31:0]                 seed;
    logic [NUM_CH*ACC_WIDTH-1:0] dut_out;
    logic [NUM_CH*ACC_WIDTH-1:0] golden_out;
    logic [NUM_CH*MIN_WIDTH-1:0] a_out;
    logic [NUM_CH*MIN_WIDTH-1:0] b_out;
    logic                        busy;
    logic                        pass;
    logic                        fail;
    logic [CNT_WIDTH-1:0]        test_cnt;
    logic [CNT_WIDTH-1:0]        err_cnt;
    logic [CNT_WIDTH-1:0]        fail_test;
    logic [NUM_CH-1:0]           fail_mask;

    modport master (
        output cset, start, num_tests, edgecase, seed, dut_out, golden_out,
        input  a_out, b_out, busy, pass, fail, test_cnt, err_cnt, fail_test, fail_mask
    );

    modport slave (
        input  cset, start, num_tests, edgecase, seed, dut_out, golden_out,
        output a_out, b_out, busy, pass, fail, test_cnt, err_cnt, fail_test, fail_mask
    );
endinterface

// File: rtl/mac_check_lfsr.sv
// 32-bit Galois LFSR with load, advance and hold; resets to state 1.
module mac_check_lfsr
    import mac_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] load_value,
    output logic [31:0] state
);
    logic [31:0] state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= 32'd1;
        end else if (load) begin
            state_reg <= load_value;
        end else if (advance) begin
            state_reg <= lfsr_step(state_reg);
        end
    end

    assign state = state_reg;
endmodule

// File: rtl/mac_check_engine.sv
// MAC check engine: drives LFSR stimulus, compares DUT against golden outputs
// and reports pass/fail. Option macro: MAC_CHECK_STOP_ON_FAIL_EN (end run on first mismatch).
module mac_check_engine
    import mac_check_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MIN_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int DELAY     = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mac_check_engine_if.slave bus
);
    localparam int NUM_OPS = 2 * NUM_CH;
    localparam logic [3:0] WARM_LAST = (DELAY > 0) ? 4'(DELAY - 1) : 4'd0;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   num_tests_reg, test_cnt_reg, err_cnt_reg, fail_test_reg;
    logic [CNT_WIDTH-1:0]   test_cnt_inc, err_cnt_inc;
    logic [2:0]             mode_reg, mode_sel;
    logic [3:0]             warm_cnt_reg;
    logic [NUM_CH-1:0]      fail_mask_reg, mismatch_mask;
    logic                   start_ok, advance, compare, mismatch, last_compare, stop_early;
    logic [31:0]            lfsr_state [NUM_OPS];
    logic [MIN_WIDTH-1:0]   stim_reg   [NUM_OPS];

    assign start_ok = !bus.cset && bus.start &&
                      (state_reg == ST_IDLE || state_reg == ST_DONE_PASS || state_reg == ST_DONE_FAIL);
    assign advance  = !bus.cset && (state_reg == ST_WARMUP || state_reg == ST_RUN);
    assign compare  = !bus.cset && (state_reg == ST_RUN);
    assign mismatch = |mismatch_mask;
    assign mode_sel = start_ok ? bus.edgecase : mode_reg;

    assign test_cnt_inc = (&test_cnt_reg) ? test_cnt_reg : test_cnt_reg + 1'b1;
    assign err_cnt_inc  = (&err_cnt_reg)  ? err_cnt_reg  : err_cnt_reg + 1'b1;
    assign last_compare = (test_cnt_inc == num_tests_reg);

`ifdef MAC_CHECK_STOP_ON_FAIL_EN
    assign stop_early = mismatch;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE_PASS, ST_DONE_FAIL: begin
                if (start_ok) begin
                    if (bus.num_tests == '0) state_next = ST_DONE_PASS;
                    else if (DELAY == 0)     state_next = ST_RUN;
                    else                     state_next = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (advance && warm_cnt_reg == WARM_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (compare && (stop_early || last_compare))
                    state_next = (err_cnt_reg == '0 && !mismatch) ? ST_DONE_PASS : ST_DONE_FAIL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_tests_reg <= '0;
            mode_reg      <= EC_RANDOM;
            warm_cnt_reg  <= '0;
            test_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            fail_test_reg <= '0;
            fail_mask_reg <= '0;
        end else if (start_ok) begin
            num_tests_reg <= bus.num_tests;
            mode_reg      <= bus.edgecase;
            warm_cnt_reg  <= '0;
            test_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            fail_test_reg <= '0;
            fail_mask_reg <= '0;
        end else begin
            if (advance && state_reg == ST_WARMUP) warm_cnt_reg <= warm_cnt_reg + 1'b1;
            if (compare) begin
                test_cnt_reg <= test_cnt_inc;
                if (mismatch) begin
                    err_cnt_reg <= err_cnt_inc;
                    // err_cnt still zero means this is the first mismatch of the run
                    if (err_cnt_reg == '0) begin
                        fail_test_reg <= test_cnt_inc;
                        fail_mask_reg <= mismatch_mask;
                    end
                end
            end
        end
    end

    // Operand k: even k is A of channel k/2, odd k is B. The stimulus register
    // always mirrors the low bits of its LFSR's current state unless overridden.
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        localparam bit IS_A = (gi % 2) == 0;
        logic [31:0]          seed_k, src;
        logic [MIN_WIDTH-1:0] op_next;

        assign seed_k = lfsr_seed(bus.seed, gi);
        assign src    = start_ok ? seed_k : lfsr_step(lfsr_state[gi]);

        mac_check_lfsr u_lfsr (
            .clk        (clk),
            .reset      (reset),
            .load       (start_ok),
            .advance    (advance),
            .load_value (seed_k),
            .state      (lfsr_state[gi])
        );

        if (MIN_WIDTH < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^src[31:MIN_WIDTH];
        end

        always_comb begin
            op_next = src[MIN_WIDTH-1:0];
            if (mode_sel == EC_RANDOM)                   op_next = src[MIN_WIDTH-1:0];
            else if (IS_A && mode_sel == EC_A_ZERO)      op_next = '0;
            else if (IS_A && mode_sel == EC_A_ONES)      op_next = '1;
            else if (!IS_A && mode_sel == EC_B_ZERO)     op_next = '0;
            else if (!IS_A && mode_sel == EC_B_ONES)     op_next = '1;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stim_reg[gi] <= '0;
            end else if (start_ok || advance) begin
                stim_reg[gi] <= op_next;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign mismatch_mask[gi] = bus.dut_out[gi*ACC_WIDTH +: ACC_WIDTH] !=
                                   bus.golden_out[gi*ACC_WIDTH +: ACC_WIDTH];
        assign bus.a_out[gi*MIN_WIDTH +: MIN_WIDTH] = stim_reg[2*gi];
        assign bus.b_out[gi*MIN_WIDTH +: MIN_WIDTH] = stim_reg[2*gi+1];
    end

    assign bus.busy      = (state_reg == ST_WARMUP) || (state_reg == ST_RUN);
    assign bus.pass      = (state_reg == ST_DONE_PASS);
    assign bus.fail      = (state_reg == ST_DONE_FAIL);
    assign bus.test_cnt  = test_cnt_reg;
    assign bus.err_cnt   = err_cnt_reg;
    assign bus.fail_test = fail_test_reg;
    assign bus.fail_mask = fail_mask_reg;
endmodule

// File: tb/tb_mac_check_engine.sv
// Self-checking bench for mac_check_engine: random stimulus and DUT outputs,
// checked against a behavioural LFSR/timeline model kept in the bench.
`timescale 1ns/1ps
module tb_mac_check_engine;
    localparam int NCH = 4;
    localparam int MW  = 8;
    localparam int AW  = 32;
    localparam int DLY = 2;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_check_engine_if #(.NUM_CH(NCH), .MIN_WIDTH(MW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    mac_check_engine #(
        .NUM_CH(NCH), .MIN_WIDTH(MW), .ACC_WIDTH(AW), .DELAY(DLY), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl [2*NCH];

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] seed, input int k);
        logic [63:0] dbl;
        logic [31:0] r;
        dbl = {seed, seed};
        r   = dbl[63 - (k % 32) -: 32];
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

    function automatic logic [MW-1:0] ref_op(input int k, input logic [2:0] mode, input logic [31:0] s);
        if (k % 2 == 0) begin
            if (mode == 3'd1) return '0;
            if (mode == 3'd2) return '1;
        end else begin
            if (mode == 3'd3) return '0;
            if (mode == 3'd4) return '1;
        end
        return s[MW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_load(input logic [31:0] sd);
        for (int k = 0; k < 2*NCH; k++) mdl[k] = ref_seed(sd, k);
    endtask

    task automatic mdl_adv();
        for (int k = 0; k < 2*NCH; k++) mdl[k] = ref_step(mdl[k]);
    endtask

    // Outputs for cycle j; compare n samples cycle DLY+n, so errors land there.
    task automatic drive_outs(input int j, input int e1, input int c1, input int e2, input int c2);
        logic [AW-1:0] v, d;
        for (int i = 0; i < NCH; i++) begin
            v = $urandom;
            d = v;
            if ((e1 > 0 && j == DLY + e1 && i == c1) || (e2 > 0 && j == DLY + e2 && i == c2)) d = v + 1'b1;
            bus.golden_out[i*AW +: AW] = v;
            bus.dut_out[i*AW +: AW]    = d;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.cset = 1'b0; bus.start = 1'b0; bus.num_tests = '0;
        bus.edgecase = '0; bus.seed = '0; bus.dut_out = '0; bus.golden_out = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        n_checks++; if (bus.a_out !== '0)     begin n_fail++; $display("FAIL reset_a_out: got %h expected 0", bus.a_out); end
        n_checks++; if (bus.b_out !== '0)     begin n_fail++; $display("FAIL reset_b_out: got %h expected 0", bus.b_out); end
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.pass !== 1'b0)    begin n_fail++; $display("FAIL reset_pass: got %b expected 0", bus.pass); end
        n_checks++; if (bus.fail !== 1'b0)    begin n_fail++; $display("FAIL reset_fail: got %b expected 0", bus.fail); end
        n_checks++; if (bus.test_cnt !== '0)  begin n_fail++; $display("FAIL reset_test_cnt: got %0d expected 0", bus.test_cnt); end
        n_checks++; if (bus.err_cnt !== '0)   begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", bus.err_cnt); end
        n_checks++; if (bus.fail_test !== '0) begin n_fail++; $display("FAIL reset_fail_test: got %0d expected 0", bus.fail_test); end
        n_checks++; if (bus.fail_mask !== '0) begin n_fail++; $display("FAIL reset_fail_mask: got %b expected 0", bus.fail_mask); end
        $display("reset: outputs checked after reset release");
    endtask

    // Runs with golden == dut; checks every busy cycle's stimulus against the LFSR model.
    task automatic run_stim_checked(input string nm, input logic [2:0] mode, input int nt);
        logic [31:0] sd;
        logic [NCH*MW-1:0] ea, eb;
        int cyc;
        sd = $urandom;
        mdl_load(sd);
        bus.num_tests = nt; bus.edgecase = mode; bus.seed = sd; bus.start = 1'b1;
        drive_outs(0, -1, 0, -1, 0);
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.pass !== 1'b1 && bus.fail !== 1'b1 && cyc < 60) begin
            drive_outs(cyc, -1, 0, -1, 0);
            for (int i = 0; i < NCH; i++) begin
                ea[i*MW +: MW] = ref_op(2*i, mode, mdl[2*i]);
                eb[i*MW +: MW] = ref_op(2*i+1, mode, mdl[2*i+1]);
            end
            n_checks++;
            if (bus.a_out !== ea || bus.b_out !== eb || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_stim cyc %0d: got a=%h b=%h busy=%b expected a=%h b=%h busy=1",
                         nm, cyc, bus.a_out, bus.b_out, bus.busy, ea, eb);
            end
            mdl_adv();
            step();
            cyc++;
        end
        n_checks++; if (cyc !== DLY + nt + 1) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", nm, cyc, DLY + nt + 1); end
        n_checks++; if (bus.pass !== 1'b1 || bus.fail !== 1'b0 || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL %s_flags: got pass=%b fail=%b busy=%b expected 1 0 0", nm, bus.pass, bus.fail, bus.busy); end
        n_checks++; if (bus.test_cnt !== nt) begin n_fail++; $display("FAIL %s_test_cnt: got %0d expected %0d", nm, bus.test_cnt, nt); end
        n_checks++; if (bus.err_cnt !== '0)  begin n_fail++; $display("FAIL %s_err_cnt: got %0d expected 0", nm, bus.err_cnt); end
        $display("%s: mode=%0d seed=%h num_tests=%0d done after %0d cycles", nm, mode, sd, nt, cyc);
    endtask

    task automatic test_pass_run();
        run_stim_checked("pass_run", 3'd0, 10);
    endtask

    task automatic test_edgecase();
        logic [2:0] modes [5];
        modes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        for (int m = 0; m < 5; m++) run_stim_checked("edgecase", modes[m], int'($urandom_range(3, 8)));
    endtask

    task automatic test_fail_inject(input int e1, input int c1, input int e2, input int c2);
        int cyc, exp_cyc, exp_tc, exp_ec;
        logic [NCH-1:0] exp_mask;
`ifdef MAC_CHECK_STOP_ON_FAIL_EN
        exp_cyc = DLY + e1 + 1; exp_tc = e1; exp_ec = 1;
`else
        exp_cyc = DLY + 10 + 1; exp_tc = 10; exp_ec = (e2 > 0) ? 2 : 1;
`endif
        exp_mask = '0;
        exp_mask[c1] = 1'b1;
        bus.num_tests = 10; bus.edgecase = 3'd0; bus.seed = $urandom; bus.start = 1'b1;
        drive_outs(0, e1, c1, e2, c2);
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.pass !== 1'b1 && bus.fail !== 1'b1 && cyc < 60) begin
            drive_outs(cyc, e1, c1, e2, c2);
            step();
            cyc++;
        end
        n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL inject_latency: got %0d expected %0d", cyc, exp_cyc); end
        n_checks++; if (bus.fail !== 1'b1 || bus.pass !== 1'b0)
            begin n_fail++; $display("FAIL inject_flags: got pass=%b fail=%b expected 0 1", bus.pass, bus.fail); end
        n_checks++; if (bus.test_cnt !== exp_tc) begin n_fail++; $display("FAIL inject_test_cnt: got %0d expected %0d", bus.test_cnt, exp_tc); end
        n_checks++; if (bus.err_cnt !== exp_ec)  begin n_fail++; $display("FAIL inject_err_cnt: got %0d expected %0d", bus.err_cnt, exp_ec); end
        n_checks++; if (bus.fail_test !== e1)    begin n_fail++; $display("FAIL inject_fail_test: got %0d expected %0d", bus.fail_test, e1); end
        n_checks++; if (bus.fail_mask !== exp_mask) begin n_fail++; $display("FAIL inject_fail_mask: got %b expected %b", bus.fail_mask, exp_mask); end
        $display("fail_inject: errors at compare %0d ch%0d and %0d ch%0d, done after %0d cycles", e1, c1, e2, c2, cyc);
    endtask

    task automatic test_cset_freeze();
        int cyc;
        logic [NCH*MW-1:0] snap_a, snap_b;
        logic [CW-1:0] snap_tc;
        bus.num_tests = 10; bus.edgecase = 3'd0; bus.seed = $urandom; bus.start = 1'b1;
        drive_outs(0, -1, 0, -1, 0);
        step();
        bus.start = 1'b0;
        cyc = 1;
        snap_a = '0; snap_b = '0; snap_tc = '0;
        while (bus.pass !== 1'b1 && bus.fail !== 1'b1 && cyc < 60) begin
            drive_outs(cyc, -1, 0, -1, 0);
            bus.start     = (cyc == 4);
            bus.num_tests = (cyc == 4) ? 3 : 10;
            bus.cset      = (cyc >= 6 && cyc <= 10);
            if (cyc == 6) begin snap_a = bus.a_out; snap_b = bus.b_out; snap_tc = bus.test_cnt; end
            if (cyc >= 7 && cyc <= 11) begin
                n_checks++;
                if (bus.a_out !== snap_a || bus.b_out !== snap_b || bus.test_cnt !== snap_tc) begin
                    n_fail++;
                    $display("FAIL cset_freeze cyc %0d: got a=%h b=%h tc=%0d expected a=%h b=%h tc=%0d",
                             cyc, bus.a_out, bus.b_out, bus.test_cnt, snap_a, snap_b, snap_tc);
                end
            end
            step();
            cyc++;
        end
        bus.start = 1'b0; bus.cset = 1'b0;
        n_checks++; if (cyc !== DLY + 10 + 5 + 1) begin n_fail++; $display("FAIL cset_latency: got %0d expected %0d", cyc, DLY + 16); end
        n_checks++; if (bus.pass !== 1'b1 || bus.test_cnt !== 10 || bus.err_cnt !== '0)
            begin n_fail++; $display("FAIL cset_totals: got pass=%b tc=%0d ec=%0d expected 1 10 0", bus.pass, bus.test_cnt, bus.err_cnt); end
        bus.cset = 1'b1; bus.start = 1'b1; bus.num_tests = 5;
        step();
        bus.cset = 1'b0; bus.start = 1'b0;
        step();
        n_checks++; if (bus.pass !== 1'b1 || bus.busy !== 1'b0 || bus.test_cnt !== 10)
            begin n_fail++; $display("FAIL cset_start_ignored: got pass=%b busy=%b tc=%0d expected 1 0 10", bus.pass, bus.busy, bus.test_cnt); end
        $display("cset_freeze: 5-cycle freeze mid-run, done after %0d cycles", cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bus.num_tests = 10; bus.edgecase = 3'd0; bus.seed = $urandom; bus.start = 1'b1;
        drive_outs(0, 2, 1, -1, 0);
        step();
        bus.start = 1'b0;
        for (cyc = 1; cyc < DLY + 6; cyc++) begin
            drive_outs(cyc, 2, 1, -1, 0);
            step();
        end
        n_checks++; if (bus.test_cnt !== 5 || bus.err_cnt !== 1 || bus.busy !== 1'b1)
            begin n_fail++; $display("FAIL reset_mid_pre: got tc=%0d ec=%0d busy=%b expected 5 1 1", bus.test_cnt, bus.err_cnt, bus.busy); end
        reset = 1'b1; bus.start = 1'b1; bus.cset = 1'b1;
        step();
        reset = 1'b0; bus.start = 1'b0; bus.cset = 1'b0;
        n_checks++;
        if ({bus.a_out, bus.b_out, bus.busy, bus.pass, bus.fail, bus.test_cnt, bus.err_cnt, bus.fail_test, bus.fail_mask} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_values: got a=%h b=%h busy=%b pass=%b fail=%b tc=%0d ec=%0d ft=%0d fm=%b expected all 0",
                     bus.a_out, bus.b_out, bus.busy, bus.pass, bus.fail, bus.test_cnt, bus.err_cnt, bus.fail_test, bus.fail_mask);
        end
        step();
        bus.num_tests = '0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++; if (bus.pass !== 1'b1 || bus.busy !== 1'b0 || bus.test_cnt !== '0)
            begin n_fail++; $display("FAIL zero_tests: got pass=%b busy=%b tc=%0d expected 1 0 0", bus.pass, bus.busy, bus.test_cnt); end
        $display("reset_mid: reset at compare 6, then num_tests=0 run");
    endtask

    initial begin
        int e1, e2, c1, c2;
        test_reset();
        test_pass_run();
        test_fail_inject(4, 2, -1, 0);
        e1 = int'($urandom_range(1, 5));
        e2 = int'($urandom_range(e1 + 1, 10));
        c1 = int'($urandom_range(0, NCH - 1));
        c2 = int'($urandom_range(0, NCH - 1));
        test_fail_inject(e1, c1, e2, c2);
        test_edgecase();
        test_cset_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
